// File: rtl/amp_pkg.sv
// Shared types and constants for the half-bridge gate driver blocks.
package amp_pkg;

  // Gate driver operating states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEAD_RISE = 3'd1,
    HI_ON     = 3'd2,
    DEAD_FALL = 3'd3,
    LO_ON     = 3'd4,
    FAULT     = 3'd5
  } dt_state_t;

  // Default floor on the dead interval, in clk cycles.
  localparam int DEFAULT_MIN_DEAD = 2;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage bit synchronizer for asynchronous inputs (fault lines, buttons).
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input into the bottom of the chain.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchronizer flops, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{1'b0}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/dead_time_gen.sv
// Half-bridge dead-time generator: turns one PWM command into complementary
// gate drives separated by a programmable dead interval, with latched fault
// shutdown.
module dead_time_gen
  import amp_pkg::*;
#(
  parameter int N           = 8,
  parameter int MIN_DEAD    = DEFAULT_MIN_DEAD,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         pwm_in,
  input  logic [N-1:0] dead_ticks,
  input  logic         fault_in,
  input  logic         clear_fault,
  output logic         gate_hi,
  output logic         gate_lo,
  output logic         fault_latched,
  output logic         dead_active
);

  localparam logic [N-1:0] MIN_DEAD_N = N'(MIN_DEAD);
  localparam logic [N-1:0] ONE_N      = N'(1);

  dt_state_t    state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic         pwm_q, pwm_d;
  logic         gate_hi_q, gate_hi_d;
  logic         gate_lo_q, gate_lo_d;
  logic         fault_latched_q, fault_latched_d;
  logic         dead_active_q, dead_active_d;
  logic         fault_s;
  logic [N-1:0] eff_dead_s;
  logic [N-1:0] load_val_s;
  logic         next_dead_s;
  logic         dead_entry_s;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_fault_sync (
    .clk(clk),
    .rst(rst),
    .d  (fault_in),
    .q  (fault_s)
  );

  // Effective dead time D = max(dead_ticks, MIN_DEAD); counter runs D-1 .. 0.
  always_comb begin
    if (dead_ticks > MIN_DEAD_N) begin
      eff_dead_s = dead_ticks;
    end else begin
      eff_dead_s = MIN_DEAD_N;
    end
    load_val_s = eff_dead_s - ONE_N;
  end

  // Single capture register for the PWM command.
  always_comb begin
    pwm_d = pwm_in;
  end

  // Next-state logic: fault beats enable, enable beats normal switching.
  always_comb begin
    state_d = state_q;
    if (fault_s) begin
      state_d = FAULT;
    end else if (state_q == FAULT) begin
      if (clear_fault) begin
        state_d = IDLE;
      end else begin
        state_d = FAULT;
      end
    end else if (!ena) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // First turn-on after idle always serves a full dead interval.
          if (pwm_q) begin
            state_d = DEAD_RISE;
          end else begin
            state_d = DEAD_FALL;
          end
        end
        LO_ON: begin
          if (pwm_q) begin
            state_d = DEAD_RISE;
          end else begin
            state_d = LO_ON;
          end
        end
        HI_ON: begin
          if (!pwm_q) begin
            state_d = DEAD_FALL;
          end else begin
            state_d = HI_ON;
          end
        end
        DEAD_RISE: begin
          // A pulse shorter than D is swallowed: the high side never came on,
          // so the low side may return without another dead wait.
          if (cnt_q == {N{1'b0}}) begin
            if (pwm_q) begin
              state_d = HI_ON;
            end else begin
              state_d = LO_ON;
            end
          end else begin
            state_d = DEAD_RISE;
          end
        end
        DEAD_FALL: begin
          if (cnt_q == {N{1'b0}}) begin
            if (pwm_q) begin
              state_d = HI_ON;
            end else begin
              state_d = LO_ON;
            end
          end else begin
            state_d = DEAD_FALL;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Dead counter: load on entry into a dead state, count down while inside.
  always_comb begin
    cnt_d        = {N{1'b0}};
    next_dead_s  = (state_d == DEAD_RISE) || (state_d == DEAD_FALL);
    dead_entry_s = next_dead_s && (state_d != state_q);
    if (dead_entry_s) begin
      cnt_d = load_val_s;
    end else if (next_dead_s && (cnt_q != {N{1'b0}})) begin
      cnt_d = cnt_q - ONE_N;
    end else begin
      cnt_d = {N{1'b0}};
    end
  end

  // Output decode from the next state so every output is a clean flop.
  always_comb begin
    gate_hi_d       = (state_d == HI_ON);
    gate_lo_d       = (state_d == LO_ON);
    fault_latched_d = (state_d == FAULT);
    dead_active_d   = (state_d == DEAD_RISE) || (state_d == DEAD_FALL);
  end

  // State, counter, input capture and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= {N{1'b0}};
      pwm_q           <= 1'b0;
      gate_hi_q       <= 1'b0;
      gate_lo_q       <= 1'b0;
      fault_latched_q <= 1'b0;
      dead_active_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pwm_q           <= pwm_d;
      gate_hi_q       <= gate_hi_d;
      gate_lo_q       <= gate_lo_d;
      fault_latched_q <= fault_latched_d;
      dead_active_q   <= dead_active_d;
    end
  end

  assign gate_hi       = gate_hi_q;
  assign gate_lo       = gate_lo_q;
  assign fault_latched = fault_latched_q;
  assign dead_active   = dead_active_q;

endmodule
